// File: rtl/port_manager.sv
// rtl/port_manager.sv - TIS node port-transfer controller with ANY/LAST targets
// Moves one word per instruction between neighbour handshake ports and the core.
module port_manager #(
    parameter int DATA_W = 11,
    parameter int NPORTS = 4,
    parameter int TGT_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [TGT_W-1:0]         src,
    input  logic [TGT_W-1:0]         dst,
    input  logic [NPORTS*DATA_W-1:0] in_data,
    input  logic [NPORTS-1:0]        in_valid,
    output logic [NPORTS-1:0]        in_ready,
    output logic [NPORTS*DATA_W-1:0] out_data,
    output logic [NPORTS-1:0]        out_valid,
    input  logic [NPORTS-1:0]        out_ready,
    output logic                     clk_en,
    output logic [DATA_W-1:0]        src_data,
    input  logic [DATA_W-1:0]        dst_data,
    output logic [NPORTS-1:0]        last_port
);

    localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [0:0] ST_SRC = 1'b0;
    localparam logic [0:0] ST_DST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [NPORTS-1:0] last_q, last_d;
    logic              src_port_q, src_port_d;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [PTR_W:0] rr_pick(input logic [NPORTS-1:0] req,
                                              input logic [PTR_W-1:0]  ptr);
        logic             found;
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] jj;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            j = int'(ptr) + k;
            if (j >= NPORTS) j = j - NPORTS;
            jj = PTR_W'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
        return {found, idx};
    endfunction

    // Returns {is_any, is_fixed, index}; fixed covers port i and LAST with a valid last port.
    function automatic logic [PTR_W+1:0] decode_tgt(input logic [TGT_W-1:0]  code,
                                                   input logic [NPORTS-1:0] last,
                                                   input logic [PTR_W-1:0]  lidx);
        logic             any_t;
        logic             fix_t;
        logic [PTR_W-1:0] idx;
        int               c;
        any_t = 1'b0;
        fix_t = 1'b0;
        idx   = '0;
        c     = int'(code);
        if (c == 1) begin
            any_t = 1'b1;
        end else if (c == 2) begin
            fix_t = |last;
            idx   = lidx;
        end else if (c >= 3 && c < 3 + NPORTS) begin
            fix_t = 1'b1;
            idx   = PTR_W'(c - 3);
        end
        return {any_t, fix_t, idx};
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NPORTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [PTR_W-1:0]  last_idx;
    logic              s_any, s_fix, s_port;
    logic [PTR_W-1:0]  s_idx, s_sel;
    logic              d_any, d_fix, d_port;
    logic [PTR_W-1:0]  d_idx;
    logic              a_found, o_found;
    logic [PTR_W-1:0]  a_idx, o_idx;
    logic              s_ok, stall, xfer;
    logic [DATA_W-1:0] port_word, out_word;

    always_comb begin
        last_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (last_q[i]) last_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        rr_d       = rr_q;
        last_d     = last_q;
        src_port_d = src_port_q;
        in_ready   = '0;
        out_valid  = '0;
        clk_en     = 1'b0;
        src_data   = '0;
        xfer       = 1'b0;

        {s_any, s_fix, s_idx} = decode_tgt(src, last_q, last_idx);
        {d_any, d_fix, d_idx} = decode_tgt(dst, last_q, last_idx);
        {a_found, a_idx}      = rr_pick(in_valid, rr_q);
        {o_found, o_idx}      = rr_pick(out_ready, rr_q);
        s_port    = s_any | s_fix;
        d_port    = d_any | d_fix;
        s_sel     = s_any ? a_idx : s_idx;
        s_ok      = s_any ? a_found : in_valid[s_sel];
        stall     = s_port & ~s_ok;
        port_word = in_data[int'(s_sel)*DATA_W +: DATA_W];
        out_word  = src_port_q ? word_q : dst_data;
        out_data  = {NPORTS{out_word}};

        case (state_q)
            ST_SRC: begin
                if (s_fix) begin
                    in_ready = NPORTS'(1) << s_idx;
                end else if (s_any && a_found) begin
                    in_ready = NPORTS'(1) << a_idx;
                end
                src_data = s_port ? port_word : '0;
                if (!stall) begin
                    if (s_any) begin
                        last_d = NPORTS'(1) << a_idx;
                        rr_d   = next_ptr(a_idx);
                    end
                    if (d_port) begin
                        state_d    = ST_DST;
                        word_d     = s_port ? port_word : dst_data;
                        src_port_d = s_port;
                    end else begin
                        clk_en = 1'b1;
                    end
                end
            end
            default: begin
                src_data = word_q;
                if (d_any) begin
                    // Offer to every port until one is ready, then narrow to the winner.
                    if (o_found) begin
                        out_valid = NPORTS'(1) << o_idx;
                        xfer      = 1'b1;
                        last_d    = NPORTS'(1) << o_idx;
                        rr_d      = next_ptr(o_idx);
                    end else begin
                        out_valid = '1;
                    end
                end else if (d_fix) begin
                    out_valid = NPORTS'(1) << d_idx;
                    xfer      = out_ready[d_idx];
                end else begin
                    xfer = 1'b1;
                end
                if (xfer) begin
                    clk_en  = 1'b1;
                    state_d = ST_SRC;
                end
            end
        endcase

        // Handshakes are quiet during reset so a pending word is dropped, not sent.
        if (reset) begin
            in_ready  = '0;
            out_valid = '0;
            clk_en    = 1'b0;
            src_data  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SRC;
            word_q     <= '0;
            rr_q       <= '0;
            last_q     <= '0;
            src_port_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            rr_q       <= rr_d;
            last_q     <= last_d;
            src_port_q <= src_port_d;
        end
    end

    assign last_port = last_q;

endmodule
